sensor_cmd_ctrl: RTL and testbench
==================================

SENSOR_CMD_CTRL -- requirements
Module: sensor_cmd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, sensor address width; valid address < 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 40, sensor frame width (hum[39:32], temp[23:16], checksum[7:0]).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 12500000, maximum cycles allowed for sensor response.
REQ-004 SHALL have parameter PERIOD_CYC, default 50000000, continuous-mode re-sample interval in cycles.
REQ-005 SHALL have port clock, input, 1, system clock (50 MHz).
REQ-006 SHALL have port reset_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port new_data, input, 1, one-cycle pulse qualifying command/address.
REQ-008 SHALL have ports command and address, input, 8 each, request fields.
REQ-009 SHALL have ports sensor_valid (input, 1, pulse) and data_sensor (input, DATA_W, frame valid with pulse).
REQ-010 SHALL have ports sensor_start (output, 1) and sensor_addr (output, ADDR_W), sensor request.
REQ-011 SHALL have ports tx_ready (input, 1), send_data_tx (output, 1), buffer_tx (output, 16), response handshake.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, CHECK, START, WAIT, FORMAT, SEND, HOLD.
REQ-014 IDLE: new_data captures command/address into registers, -> CHECK; otherwise stay.
REQ-015 CHECK: command > 6 -> response {0x0C,0xFF}; address[7:ADDR_W] non-zero -> {0x0D,0xFF}; both go to SEND; else -> START.
REQ-016 CHECK: commands 5/6 with no matching continuous mode active SHALL return {0x0C,0xFF}.
REQ-017 START: sensor_start high exactly one cycle with sensor_addr = captured address; timeout counter cleared; -> WAIT.
REQ-018 WAIT: sensor_valid latches data_sensor, -> FORMAT; counter reaching TIMEOUT_CYC-1 without sensor_valid -> response {0x1F,0xFF}, -> SEND.
REQ-019 FORMAT: all-ones frame -> {0x1F,0xFF}; cmd0 -> {0x07,0xFF}; cmd1/3 -> {0x09,temp}; cmd2/4 -> {0x08,hum}.
REQ-020 SEND: send_data_tx and buffer_tx held stable until tx_ready sampled high; transfer completes that cycle.
REQ-021 After SEND: continuous mode (cmd3/4) active -> HOLD; otherwise -> IDLE.
REQ-022 HOLD: period counter to PERIOD_CYC-1 then -> START; new_data with cmd5 (stop temp, mode 3) or cmd6 (stop hum, mode 4) at the same address -> response {0x0A,0xFF}/{0x0B,0xFF}, mode cleared, -> SEND.
REQ-023 HOLD: any other new_data SHALL be ignored; new_data outside IDLE/HOLD SHALL be ignored (no queueing).
REQ-024 Stop command arriving while WAIT/SEND in continuous mode SHALL be latched as a pending stop and served on entry to HOLD.
REQ-025 Counters SHALL be width $clog2 of their limit, saturate-free, cleared on every state entry.
REQ-026 buffer_tx SHALL hold its last value outside SEND; send_data_tx low outside SEND.

Reset
REQ-027 reset_n low SHALL force IDLE, clear counters, continuous mode, pending stop, captured registers, latched frame.
REQ-028 During reset: sensor_start=0, sensor_addr=0, send_data_tx=0, buffer_tx=16'h0000, busy=0.
REQ-029 Reset mid-WAIT or mid-SEND SHALL abort without emitting a response.

Configuration
REQ-030 Macro SENSOR_CHECKSUM_EN defined: FORMAT SHALL check (hum_int+hum_dec+temp_int+temp_dec) mod 256 == data_sensor[7:0]; mismatch -> {0x1E,0xFF}.
REQ-031 Macro SENSOR_CHECKSUM_EN undefined: checksum byte ignored, no adder logic synthesised, 0x1E never produced.

Structure
REQ-032 Shared package SHALL hold state encoding, command codes 0..6, response codes 0x07-0x0D, 0x1E, 0x1F, and the all-ones error frame constant.
REQ-033 Response formatting (FORMAT/CHECK codes) SHALL be a combinational sub-module sensor_resp_fmt; FSM and counters stay in sensor_cmd_ctrl.

Verification (TIMEOUT_CYC=100, PERIOD_CYC=200)
REQ-034 cmd1 addr3, sensor_valid after 20 cycles with temp=0x19 -> sensor_addr=3, buffer_tx=0x0919 in SEND.
REQ-035 cmd0 addr2, no sensor_valid -> after 100 cycles in WAIT buffer_tx=0x1FFF, then IDLE.
REQ-036 cmd9 addr0 -> 0x0CFF; cmd1 addr40 -> 0x0DFF; sensor_start never asserted.
REQ-037 cmd4 addr5, hum=0x3C, tx_ready held low 10 cycles -> 0x083C stable 10 cycles; re-sample after 200; cmd6 addr5 in HOLD -> 0x0BFF then IDLE; cmd6 addr4 ignored.
REQ-038 With SENSOR_CHECKSUM_EN, frame 0x3C00190000 (checksum 0x00, expected 0x55) on cmd2 -> 0x1EFF; without macro -> 0x083C.
REQ-039 reset_n pulsed low during WAIT -> all outputs zero immediately, no response emitted, next cmd0 served normally.

Source files
------------

// File: rtl/sensor_cmd_ctrl_pkg.sv
// Shared encodings for the sensor command controller: FSM states, command and response codes.
// Optional checksum verification is enabled with the SENSOR_CHECKSUM_EN macro.
package sensor_cmd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_START,
        ST_WAIT,
        ST_FORMAT,
        ST_SEND,
        ST_HOLD
    } state_e;

    localparam logic [7:0] CMD_STATUS    = 8'd0;
    localparam logic [7:0] CMD_TEMP      = 8'd1;
    localparam logic [7:0] CMD_HUM       = 8'd2;
    localparam logic [7:0] CMD_TEMP_CONT = 8'd3;
    localparam logic [7:0] CMD_HUM_CONT  = 8'd4;
    localparam logic [7:0] CMD_STOP_TEMP = 8'd5;
    localparam logic [7:0] CMD_STOP_HUM  = 8'd6;

    localparam logic [7:0] RSP_STATUS     = 8'h07;
    localparam logic [7:0] RSP_HUM        = 8'h08;
    localparam logic [7:0] RSP_TEMP       = 8'h09;
    localparam logic [7:0] RSP_STOP_TEMP  = 8'h0A;
    localparam logic [7:0] RSP_STOP_HUM   = 8'h0B;
    localparam logic [7:0] RSP_BAD_CMD    = 8'h0C;
    localparam logic [7:0] RSP_BAD_ADDR   = 8'h0D;
    localparam logic [7:0] RSP_CHKSUM     = 8'h1E;
    localparam logic [7:0] RSP_SENSOR_ERR = 8'h1F;
    localparam logic [7:0] RSP_FILL       = 8'hFF;

    // A sensor that is absent or stuck drives the bus high, giving this frame.
    localparam logic [39:0] ERR_FRAME = '1;

    function automatic logic [15:0] resp_word(input logic [7:0] code, input logic [7:0] payload);
        return {code, payload};
    endfunction

endpackage

// File: rtl/sensor_resp_fmt.sv
// Combinational response builder: request validation codes and sensor-frame formatting.
// With SENSOR_CHECKSUM_EN defined the frame checksum byte is verified.
module sensor_resp_fmt
    import sensor_cmd_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 40
) (
    input  logic [7:0]        cmd_i,
    input  logic [7:0]        addr_i,
    input  logic [DATA_W-1:0] frame_i,
    output logic              chk_err_o,
    output logic [15:0]       chk_resp_o,
    output logic [15:0]       fmt_resp_o
);

    logic [7:0] hum_int;
    logic [7:0] temp_int;

    assign hum_int  = frame_i[39:32];
    assign temp_int = frame_i[23:16];

`ifdef SENSOR_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = frame_i[39:32] + frame_i[31:24] + frame_i[23:16] + frame_i[15:8];
`else
    logic unused_chk_bits;
    assign unused_chk_bits = ^{frame_i[31:24], frame_i[15:0]};
`endif

    always_comb begin
        chk_err_o  = 1'b1;
        chk_resp_o = resp_word(RSP_BAD_CMD, RSP_FILL);
        if (cmd_i > CMD_STOP_HUM) begin
            chk_resp_o = resp_word(RSP_BAD_CMD, RSP_FILL);
        end else if ((addr_i >> ADDR_W) != 8'd0) begin
            chk_resp_o = resp_word(RSP_BAD_ADDR, RSP_FILL);
        end else if (cmd_i == CMD_STOP_TEMP || cmd_i == CMD_STOP_HUM) begin
            // Stop requests reaching validation never have a matching continuous mode.
            chk_resp_o = resp_word(RSP_BAD_CMD, RSP_FILL);
        end else begin
            chk_err_o = 1'b0;
        end
    end

    always_comb begin
        fmt_resp_o = resp_word(RSP_BAD_CMD, RSP_FILL);
        if (frame_i == DATA_W'(ERR_FRAME)) begin
            fmt_resp_o = resp_word(RSP_SENSOR_ERR, RSP_FILL);
        end
`ifdef SENSOR_CHECKSUM_EN
        else if (csum != frame_i[7:0]) begin
            fmt_resp_o = resp_word(RSP_CHKSUM, RSP_FILL);
        end
`endif
        else begin
            case (cmd_i)
                CMD_STATUS:                fmt_resp_o = resp_word(RSP_STATUS, RSP_FILL);
                CMD_TEMP, CMD_TEMP_CONT:   fmt_resp_o = resp_word(RSP_TEMP, temp_int);
                CMD_HUM, CMD_HUM_CONT:     fmt_resp_o = resp_word(RSP_HUM, hum_int);
                default:                   fmt_resp_o = resp_word(RSP_BAD_CMD, RSP_FILL);
            endcase
        end
    end

endmodule

// File: rtl/sensor_cmd_ctrl.sv
// Sensor command controller: request capture, sensor handshake with timeout, continuous sampling.
// Build with SENSOR_CHECKSUM_EN defined to reject frames whose checksum byte does not match.
module sensor_cmd_ctrl
    import sensor_cmd_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 40,
    parameter int TIMEOUT_CYC = 12500000,
    parameter int PERIOD_CYC  = 50000000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              new_data,
    input  logic [7:0]        command,
    input  logic [7:0]        address,
    input  logic              sensor_valid,
    input  logic [DATA_W-1:0] data_sensor,
    output logic              sensor_start,
    output logic [ADDR_W-1:0] sensor_addr,
    input  logic              tx_ready,
    output logic              send_data_tx,
    output logic [15:0]       buffer_tx,
    output logic              busy
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(PERIOD_CYC - 1);

    state_e             state_q, state_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         addr_q, addr_d;
    logic [DATA_W-1:0]  frame_q, frame_d;
    logic [15:0]        resp_q, resp_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic               cont_q, cont_d;
    logic               pend_q, pend_d;

    logic               chk_err;
    logic [15:0]        chk_resp;
    logic [15:0]        fmt_resp;
    logic               stop_match;
    logic [15:0]        stop_resp;

    sensor_resp_fmt #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fmt (
        .cmd_i      (cmd_q),
        .addr_i     (addr_q),
        .frame_i    (frame_q),
        .chk_err_o  (chk_err),
        .chk_resp_o (chk_resp),
        .fmt_resp_o (fmt_resp)
    );

    // A stop only counts when it names the running mode and the address being sampled.
    assign stop_match = new_data && (address == addr_q) &&
                        ((cmd_q == CMD_TEMP_CONT && command == CMD_STOP_TEMP) ||
                         (cmd_q == CMD_HUM_CONT  && command == CMD_STOP_HUM));
    assign stop_resp  = (cmd_q == CMD_TEMP_CONT) ? resp_word(RSP_STOP_TEMP, RSP_FILL)
                                                 : resp_word(RSP_STOP_HUM, RSP_FILL);

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        frame_d = frame_q;
        resp_d  = resp_q;
        cont_d  = cont_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (new_data) begin
                    cmd_d   = command;
                    addr_d  = address;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                pend_d = 1'b0;
                if (chk_err) begin
                    resp_d  = chk_resp;
                    state_d = ST_SEND;
                end else begin
                    cont_d  = (cmd_q == CMD_TEMP_CONT) || (cmd_q == CMD_HUM_CONT);
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (cont_q && stop_match) pend_d = 1'b1;
                if (sensor_valid) begin
                    frame_d = data_sensor;
                    state_d = ST_FORMAT;
                end else if (tmo_q == TMO_MAX) begin
                    resp_d  = resp_word(RSP_SENSOR_ERR, RSP_FILL);
                    state_d = ST_SEND;
                end
            end
            ST_FORMAT: begin
                resp_d  = fmt_resp;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (cont_q && stop_match) pend_d = 1'b1;
                if (tx_ready) state_d = cont_q ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (pend_q || stop_match) begin
                    resp_d  = stop_resp;
                    cont_d  = 1'b0;
                    pend_d  = 1'b0;
                    state_d = ST_SEND;
                end else if (per_q == PER_MAX) begin
                    state_d = ST_START;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counters run only while staying in their state, so any entry restarts them at zero.
        tmo_d = (state_q == ST_WAIT && state_d == ST_WAIT) ? tmo_q + TMO_W'(1) : '0;
        per_d = (state_q == ST_HOLD && state_d == ST_HOLD) ? per_q + PER_W'(1) : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            addr_q  <= '0;
            frame_q <= '0;
            resp_q  <= '0;
            tmo_q   <= '0;
            per_q   <= '0;
            cont_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            frame_q <= frame_d;
            resp_q  <= resp_d;
            tmo_q   <= tmo_d;
            per_q   <= per_d;
            cont_q  <= cont_d;
            pend_q  <= pend_d;
        end
    end

    assign sensor_start = (state_q == ST_START);
    assign sensor_addr  = addr_q[ADDR_W-1:0];
    assign send_data_tx = (state_q == ST_SEND);
    assign buffer_tx    = resp_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sensor_cmd_ctrl.sv
// Bench for sensor_cmd_ctrl: vector table, continuous/stop/reset sequences and randomized requests.
module tb_sensor_cmd_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 40;
    localparam int TMO    = 100;
    localparam int PER    = 200;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              new_data = 1'b0;
    logic [7:0]        command = '0;
    logic [7:0]        address = '0;
    logic              sensor_valid = 1'b0;
    logic [DATA_W-1:0] data_sensor = '0;
    logic              sensor_start;
    logic [ADDR_W-1:0] sensor_addr;
    logic              tx_ready = 1'b0;
    logic              send_data_tx;
    logic [15:0]       buffer_tx;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sensor_cmd_ctrl #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TMO),
        .PERIOD_CYC  (PER)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .new_data     (new_data),
        .command      (command),
        .address      (address),
        .sensor_valid (sensor_valid),
        .data_sensor  (data_sensor),
        .sensor_start (sensor_start),
        .sensor_addr  (sensor_addr),
        .tx_ready     (tx_ready),
        .send_data_tx (send_data_tx),
        .buffer_tx    (buffer_tx),
        .busy         (busy)
    );

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [39:0] frame;
        int          delay;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rules: validation first, then sensor outcome, then command-specific payload.
    function automatic logic [15:0] model_resp(input logic [7:0] cmd, input logic [7:0] addr,
                                               input logic [39:0] frame, input bit timed_out);
        if (cmd > 8'd6) return 16'h0CFF;
        if (addr >= 8'd32) return 16'h0DFF;
        if (cmd == 8'd5 || cmd == 8'd6) return 16'h0CFF;
        if (timed_out) return 16'h1FFF;
        if (frame == 40'hFF_FFFF_FFFF) return 16'h1FFF;
`ifdef SENSOR_CHECKSUM_EN
        if (8'(frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8]) != frame[7:0])
            return 16'h1EFF;
`endif
        if (cmd == 8'd0) return 16'h07FF;
        if (cmd == 8'd1 || cmd == 8'd3) return {8'h09, frame[23:16]};
        return {8'h08, frame[39:32]};
    endfunction

    function automatic bit needs_sensor(input logic [7:0] cmd, input logic [7:0] addr);
        return (cmd <= 8'd4) && (addr < 8'd32);
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_cmd(input logic [7:0] cmd, input logic [7:0] addr);
        command  = cmd;
        address  = addr;
        new_data = 1'b1;
        step();
        new_data = 1'b0;
    endtask

    // Entered on the cycle sensor_start is visible; returns on the first SEND cycle.
    task automatic sensor_phase(input logic [39:0] frame, input int delay, input string name);
        int i = 0;
        while (!send_data_tx && i < 300) begin
            step();
            i++;
            sensor_valid = 1'b0;
            if (delay >= 0 && i == delay + 1) begin
                data_sensor  = frame;
                sensor_valid = 1'b1;
            end
        end
        sensor_valid = 1'b0;
        chk({name, " latency"}, 32'(i), 32'((delay < 0) ? TMO + 1 : delay + 3));
    endtask

    task automatic serve_send(input logic [15:0] exp, input int hold, input string name);
        int bad = 0;
        chk({name, " send"}, 32'(send_data_tx), 32'd1);
        chk({name, " data"}, 32'(buffer_tx), 32'(exp));
        repeat (hold) begin
            tx_ready = 1'b0;
            step();
            if (!send_data_tx || buffer_tx !== exp) bad++;
        end
        chk({name, " stable"}, 32'(bad), 32'd0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk({name, " released"}, 32'(send_data_tx), 32'd0);
        chk({name, " buf hold"}, 32'(buffer_tx), 32'(exp));
    endtask

    task automatic wait_send(input string name);
        int n = 0;
        while (!send_data_tx && n < 10) begin
            step();
            n++;
        end
        chk({name, " reached send"}, 32'(send_data_tx), 32'd1);
    endtask

    task automatic issue(input logic [7:0] cmd, input logic [7:0] addr, input logic [39:0] frame,
                         input int delay, input logic [15:0] exp, input int hold, input string name);
        int n = 0;
        pulse_cmd(cmd, addr);
        while (!sensor_start && !send_data_tx && n < 20) begin
            step();
            n++;
        end
        chk({name, " start"}, 32'(sensor_start), 32'(needs_sensor(cmd, addr)));
        if (sensor_start) begin
            chk({name, " addr"}, 32'(sensor_addr), 32'(addr[4:0]));
            sensor_phase(frame, delay, name);
        end
        serve_send(exp, hold, name);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr, input logic [39:0] frame,
                           input int delay, input logic [15:0] exp, input int hold, input string name);
        issue(cmd, addr, frame, delay, exp, hold, name);
        chk({name, " idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'd1,   8'd3,   40'h3C_00_19_00_55, 20, 16'h0919};
        tbl[1]  = '{8'd0,   8'd2,   40'h00_00_00_00_00, -1, 16'h1FFF};
        tbl[2]  = '{8'd9,   8'd0,   40'h00_00_00_00_00,  0, 16'h0CFF};
        tbl[3]  = '{8'd1,   8'd40,  40'h00_00_00_00_00,  0, 16'h0DFF};
`ifdef SENSOR_CHECKSUM_EN
        tbl[4]  = '{8'd2,   8'd1,   40'h3C_00_19_00_00,  3, 16'h1EFF};
`else
        tbl[4]  = '{8'd2,   8'd1,   40'h3C_00_19_00_00,  3, 16'h083C};
`endif
        tbl[5]  = '{8'd5,   8'd1,   40'h00_00_00_00_00,  0, 16'h0CFF};
        tbl[6]  = '{8'd6,   8'd31,  40'h00_00_00_00_00,  0, 16'h0CFF};
        tbl[7]  = '{8'd2,   8'd31,  40'hFF_FF_FF_FF_FF,  0, 16'h1FFF};
        tbl[8]  = '{8'd0,   8'd0,   40'h10_20_30_40_A0,  1, 16'h07FF};
        tbl[9]  = '{8'd255, 8'd255, 40'h00_00_00_00_00,  0, 16'h0CFF};
        tbl[10] = '{8'd1,   8'd31,  40'h00_00_7F_00_7F, 99, 16'h097F};

        repeat (3) step();
        chk("reset sensor_start", 32'(sensor_start), 32'd0);
        chk("reset sensor_addr", 32'(sensor_addr), 32'd0);
        chk("reset send_data_tx", 32'(send_data_tx), 32'd0);
        chk("reset buffer_tx", 32'(buffer_tx), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        step();

        for (int k = 0; k < 11; k++) begin
            run_txn(tbl[k].cmd, tbl[k].addr, tbl[k].frame, tbl[k].delay, tbl[k].exp, k % 3,
                    $sformatf("vec%0d", k));
        end

        // Continuous humidity: hold-off with tx_ready low, ignored foreign stop, resample, stop.
        begin
            int n;
            issue(8'd4, 8'd5, 40'h3C_00_19_00_55, 10, 16'h083C, 10, "cont first");
            chk("cont hold busy", 32'(busy), 32'd1);
            n = 1;
            while (!sensor_start && n < 400) begin
                if (n == 5) begin
                    command  = 8'd6;
                    address  = 8'd4;
                    new_data = 1'b1;
                end
                step();
                new_data = 1'b0;
                n++;
            end
            chk("cont resample period", 32'(n), 32'(PER + 1));
            chk("cont resample addr", 32'(sensor_addr), 32'd5);
            sensor_phase(40'h41_00_19_00_5A, 4, "cont second");
            serve_send(16'h0841, 2, "cont second");
            chk("cont still busy", 32'(busy), 32'd1);
            pulse_cmd(8'd6, 8'd5);
            wait_send("stop hum");
            serve_send(16'h0BFF, 3, "stop hum");
            chk("stop hum idle", 32'(busy), 32'd0);
        end

        // Continuous temperature with the stop arriving during WAIT.
        begin
            int n = 0;
            pulse_cmd(8'd3, 8'd7);
            while (!sensor_start && n < 10) begin
                step();
                n++;
            end
            chk("pend start", 32'(sensor_start), 32'd1);
            step();
            step();
            pulse_cmd(8'd5, 8'd7);
            data_sensor  = 40'h00_00_1A_00_1A;
            sensor_valid = 1'b1;
            step();
            sensor_valid = 1'b0;
            wait_send("pend data");
            serve_send(16'h091A, 1, "pend data");
            wait_send("pend stop");
            serve_send(16'h0AFF, 0, "pend stop");
            chk("pend idle", 32'(busy), 32'd0);
        end

        // Reset in the middle of WAIT aborts silently.
        begin
            int n = 0;
            int bad = 0;
            pulse_cmd(8'd0, 8'd2);
            while (!sensor_start && n < 10) begin
                step();
                n++;
            end
            repeat (5) step();
            #1 reset_n = 1'b0;
            #1;
            chk("rst busy", 32'(busy), 32'd0);
            chk("rst outputs", 32'({sensor_start, sensor_addr, send_data_tx, buffer_tx}), 32'd0);
            step();
            reset_n = 1'b1;
            repeat (TMO + 10) begin
                step();
                if (send_data_tx || busy) bad++;
            end
            chk("rst no response", 32'(bad), 32'd0);
            run_txn(8'd0, 8'd2, 40'h01_02_03_04_0A, 5, 16'h07FF, 1, "after reset");
        end

        for (int r = 0; r < 40; r++) begin
            logic [63:0] rnd;
            logic [39:0] frame;
            logic [7:0]  cmd;
            logic [7:0]  addr;
            int          delay;
            cmd = 8'($urandom_range(0, 9));
            if (cmd == 8'd3 || cmd == 8'd4) cmd = cmd - 8'd2;
            addr = 8'($urandom_range(0, 40));
            rnd = {$urandom, $urandom};
            frame = rnd[39:0];
            if ($urandom_range(0, 3) != 0)
                frame[7:0] = 8'(frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8]);
            if ($urandom_range(0, 9) == 0) frame = '1;
            delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 40));
            run_txn(cmd, addr, frame, delay, model_resp(cmd, addr, frame, delay < 0),
                    int'($urandom_range(0, 3)), $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
